// File: rtl/drum_step_sequencer_pkg.sv
// Shared types, fixed-point constants and the saturation helper for the drum
// membrane step controller and the patch/node logic.
package drum_step_sequencer_pkg;

  // 1.17 signed fixed point used across the membrane datapath
  localparam int unsigned FP_W    = 18;
  localparam int unsigned FP_FRAC = 17;

  // Step controller states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_ROTATE = 3'd4,
    ST_EMIT   = 3'd5
  } seq_state_e;

  // Clamp a one-bit-wider fixed-point value into [lo, hi]
  function automatic logic signed [FP_W-1:0] sat_fp(
    input logic signed [FP_W:0]   value,
    input logic signed [FP_W-1:0] lo,
    input logic signed [FP_W-1:0] hi
  );
    logic signed [FP_W:0] lo_x;
    logic signed [FP_W:0] hi_x;
    lo_x = {lo[FP_W-1], lo};
    hi_x = {hi[FP_W-1], hi};
    if (value > hi_x) begin
      return hi;
    end else if (value < lo_x) begin
      return lo;
    end else begin
      return value[FP_W-1:0];
    end
  endfunction

endpackage

// File: rtl/drum_step_sequencer_rho_update.sv
// Effective tension for the next step: rho_base plus the scaled energy of the
// centre sample, clamped to RHO_MAX. Purely combinational so a pipeline stage
// can be inserted later without touching the controller.
module rho_update
  import drum_step_sequencer_pkg::*;
#(
  parameter int unsigned             GAIN_SHIFT = 4,
  parameter logic signed [FP_W-1:0]  RHO_MAX    = 18'sh0FFFF
) (
  input  logic signed [FP_W-1:0] sample,
  input  logic signed [FP_W-1:0] rho_base,
  output logic signed [FP_W-1:0] rho_next_c
);

  localparam int unsigned PROD_W = 2 * FP_W;
  localparam int unsigned SUM_W  = FP_W + 1;
  localparam logic signed [FP_W-1:0] RHO_MIN = {1'b1, {(FP_W-1){1'b0}}};

  logic signed [PROD_W-1:0] sample_x;
  logic signed [PROD_W-1:0] base_x;
  logic signed [PROD_W-1:0] product;
  logic signed [PROD_W-1:0] scaled;
  logic signed [SUM_W-1:0]  sum;

  // Square, drop the fraction and gain bits, add to the base, saturate
  always_comb begin
    sample_x   = {{FP_W{sample[FP_W-1]}}, sample};
    base_x     = {{FP_W{rho_base[FP_W-1]}}, rho_base};
    product    = sample_x * sample_x;
    scaled     = product >>> (FP_FRAC + GAIN_SHIFT);
    // scaled is non-negative and below 2^18, so the 19-bit sum cannot wrap
    sum        = SUM_W'(base_x + scaled);
    rho_next_c = sat_fp(sum, RHO_MIN, RHO_MAX);
  end

endmodule

// File: rtl/drum_step_sequencer.sv
// Time-step controller for the drum membrane patch array: starts every patch
// sweep, gathers completion, rotates the time buffers, updates rho and hands
// one sample per step to the audio path.
module drum_step_sequencer
  import drum_step_sequencer_pkg::*;
#(
  parameter int unsigned            NUM_PATCH  = 4,
  parameter int unsigned            TIMEOUT    = 64,
  parameter int unsigned            GAIN_SHIFT = 4,
  parameter logic signed [FP_W-1:0] RHO_MAX    = 18'sh0FFFF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    hit,
  input  logic [NUM_PATCH-1:0]    patch_done,
  input  logic signed [FP_W-1:0]  sample_in,
  input  logic signed [FP_W-1:0]  rho_base,
  output logic                    load_init,
  output logic                    patch_start,
  output logic                    rotate,
  output logic signed [FP_W-1:0]  rho_out,
  output logic signed [FP_W-1:0]  sample_out,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic [15:0]             step_count,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [NUM_PATCH-1:0] ALL_DONE = '1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  seq_state_e state;
  seq_state_e next_state;

  logic [NUM_PATCH-1:0]   done_mask;
  logic [TMO_W-1:0]       tmo_cnt;
  logic                   hit_pending;

  logic [NUM_PATCH-1:0]   mask_merged;
  logic [NUM_PATCH-1:0]   done_mask_d;
  logic [TMO_W-1:0]       tmo_cnt_d;
  logic                   hit_pending_d;
  logic                   timeout_err_d;
  logic [15:0]            step_count_d;
  logic signed [FP_W-1:0] rho_out_d;
  logic signed [FP_W-1:0] sample_out_d;
  logic signed [FP_W-1:0] rho_next_c;

  rho_update #(
    .GAIN_SHIFT (GAIN_SHIFT),
    .RHO_MAX    (RHO_MAX)
  ) u_rho_update (
    .sample     (sample_in),
    .rho_base   (rho_base),
    .rho_next_c (rho_next_c)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and next-value logic for the step sequence
  always_comb begin
    next_state    = state;
    done_mask_d   = done_mask;
    tmo_cnt_d     = tmo_cnt;
    hit_pending_d = hit_pending | hit;
    timeout_err_d = timeout_err;
    step_count_d  = step_count;
    rho_out_d     = rho_out;
    sample_out_d  = sample_out;
    mask_merged   = done_mask | patch_done;

    case (state)
      ST_IDLE: begin
        if (run) begin
          next_state = ST_INIT;
        end
      end
      ST_INIT: begin
        // a hit landing in this very cycle is treated as serviced
        step_count_d  = '0;
        hit_pending_d = 1'b0;
        rho_out_d     = rho_base;
        next_state    = ST_START;
      end
      ST_START: begin
        done_mask_d = patch_done;
        tmo_cnt_d   = '0;
        next_state  = ST_WAIT;
      end
      ST_WAIT: begin
        done_mask_d = mask_merged;
        if (mask_merged == ALL_DONE) begin
          next_state = ST_ROTATE;
        end else if (tmo_cnt == TMO_LAST) begin
          timeout_err_d = 1'b1;
          next_state    = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt + TMO_W'(1);
        end
      end
      ST_ROTATE: begin
        sample_out_d = sample_in;
        step_count_d = step_count + 16'd1;
        rho_out_d    = rho_next_c;
        next_state   = ST_EMIT;
      end
      ST_EMIT: begin
        if (sample_ready) begin
          if (hit_pending) begin
            next_state = ST_INIT;
          end else if (!run) begin
            next_state = ST_IDLE;
          end else begin
            next_state = ST_START;
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers; strobes are decoded from the next state
  // so each one is high for exactly the cycle spent in its state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_mask    <= '0;
      tmo_cnt      <= '0;
      hit_pending  <= 1'b0;
      timeout_err  <= 1'b0;
      step_count   <= '0;
      rho_out      <= '0;
      sample_out   <= '0;
      load_init    <= 1'b0;
      patch_start  <= 1'b0;
      rotate       <= 1'b0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      done_mask    <= done_mask_d;
      tmo_cnt      <= tmo_cnt_d;
      hit_pending  <= hit_pending_d;
      timeout_err  <= timeout_err_d;
      step_count   <= step_count_d;
      rho_out      <= rho_out_d;
      sample_out   <= sample_out_d;
      load_init    <= (next_state == ST_INIT);
      patch_start  <= (next_state == ST_START);
      rotate       <= (next_state == ST_ROTATE);
      sample_valid <= (next_state == ST_EMIT);
      busy         <= (next_state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Randomised bench for drum_step_sequencer with a step-level reference model.
module tb_drum_step_sequencer;

  localparam int NP  = 4;
  localparam int TMO = 64;
  localparam int GS  = 4;
  localparam longint RHO_MAX_V = 65535;

  logic              clock;
  logic              reset;
  logic              run;
  logic              hit;
  logic [NP-1:0]     patch_done;
  logic signed [17:0] sample_in;
  logic signed [17:0] rho_base;
  logic              load_init;
  logic              patch_start;
  logic              rotate;
  logic signed [17:0] rho_out;
  logic signed [17:0] sample_out;
  logic              sample_valid;
  logic              sample_ready;
  logic [15:0]       step_count;
  logic              busy;
  logic              timeout_err;

  int n_cmp;
  int n_err;
  int exp_steps;
  bit hit_pend;
  int dly[NP];

  drum_step_sequencer #(
    .NUM_PATCH  (NP),
    .TIMEOUT    (TMO),
    .GAIN_SHIFT (GS),
    .RHO_MAX    (18'sh0FFFF)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
    .hit          (hit),
    .patch_done   (patch_done),
    .sample_in    (sample_in),
    .rho_base     (rho_base),
    .load_init    (load_init),
    .patch_start  (patch_start),
    .rotate       (rotate),
    .rho_out      (rho_out),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .step_count   (step_count),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // rho = min(RHO_MAX, base + floor(s^2 / 2^(17+GS)))
  function automatic longint model_rho(input longint base, input longint s);
    longint e;
    longint r;
    e = (s * s) / (longint'(1) << (17 + GS));
    r = base + e;
    if (r > RHO_MAX_V) r = RHO_MAX_V;
    return r;
  endfunction

  function automatic logic [NP-1:0] done_at(input int j);
    logic [NP-1:0] b;
    b = '0;
    for (int i = 0; i < NP; i++) if (dly[i] == j) b[i] = 1'b1;
    return b;
  endfunction

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_load_init"}, load_init, 0);
    check_eq({tag, "_patch_start"}, patch_start, 0);
    check_eq({tag, "_rotate"}, rotate, 0);
    check_eq({tag, "_sample_valid"}, sample_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_timeout_err"}, timeout_err, 0);
    check_eq({tag, "_rho_out"}, rho_out, 0);
    check_eq({tag, "_sample_out"}, sample_out, 0);
    check_eq({tag, "_step_count"}, step_count, 0);
  endtask

  // Called at the falling edge of an idle cycle; leaves us in the START cycle
  task automatic start_run();
    run = 1'b1;
    @(negedge clock);
    check_eq("init_load_init", load_init, 1);
    check_eq("init_patch_start", patch_start, 0);
    check_eq("init_busy", busy, 1);
    @(negedge clock);
    hit_pend  = 1'b0;
    exp_steps = 0;
    check_eq("start_patch_start", patch_start, 1);
    check_eq("start_load_init", load_init, 0);
    check_eq("start_step_count", step_count, 0);
    check_eq("start_rho_out", rho_out, rho_base);
  endtask

  // One time step, entered at the falling edge of the START cycle.
  // dly[i] < 0 marks a patch that never completes.
  task automatic do_step(input logic signed [17:0] s, input logic signed [17:0] base,
                         input int stall, input int hit_at, input int drop_at,
                         input bit abort, output bit ended_idle);
    int  dmax;
    bit  never;
    int  rot_at;
    longint exp_rho;
    ended_idle = 1'b0;
    never = 1'b0;
    dmax  = 0;
    for (int i = 0; i < NP; i++) begin
      if (dly[i] < 0) never = 1'b1;
      else if (dly[i] > dmax) dmax = dly[i];
    end
    rot_at  = ((dmax < 1) ? 1 : dmax) + 1;
    exp_rho = model_rho(longint'(base), longint'(s));
    sample_in    = s;
    rho_base     = base;
    sample_ready = 1'b0;
    check_eq("step_patch_start", patch_start, 1);
    patch_done = done_at(0);
    for (int j = 1; j <= TMO + 1; j++) begin
      @(negedge clock);
      patch_done = '0;
      hit = 1'b0;
      if (never && j == TMO + 1) begin
        check_eq("tmo_err", timeout_err, 1);
        check_eq("tmo_busy", busy, 0);
        check_eq("tmo_rotate", rotate, 0);
        ended_idle = 1'b1;
        return;
      end
      check_eq("rotate_timing", rotate, (!never && j == rot_at) ? 1 : 0);
      if (!never && j == rot_at) begin
        sample_ready = (stall == 0);
        break;
      end
      patch_done = done_at(j);
      if (j == hit_at) begin
        hit = 1'b1;
        hit_pend = 1'b1;
      end
      if (j == drop_at) run = 1'b0;
    end
    // first EMIT cycle
    @(negedge clock);
    exp_steps = (exp_steps + 1) % 65536;
    check_eq("emit_valid", sample_valid, 1);
    check_eq("emit_rotate", rotate, 0);
    check_eq("emit_sample_out", sample_out, s);
    check_eq("emit_rho_out", rho_out, exp_rho);
    check_eq("emit_step_count", step_count, exp_steps);
    sample_in = 18'($urandom);
    if (abort) begin
      reset = 1'b0;
      run = 1'b0;
      sample_ready = 1'b0;
      #1;
      check_reset_values("abort");
      @(negedge clock);
      reset = 1'b1;
      hit_pend = 1'b0;
      exp_steps = 0;
      ended_idle = 1'b1;
      return;
    end
    for (int i = 1; i <= stall; i++) begin
      @(negedge clock);
      check_eq("stall_valid", sample_valid, 1);
      check_eq("stall_sample_out", sample_out, s);
      sample_in = 18'($urandom);
      if (i == stall) sample_ready = 1'b1;
    end
    @(negedge clock);
    sample_ready = 1'b0;
    check_eq("post_valid", sample_valid, 0);
    if (hit_pend) begin
      check_eq("hit_load_init", load_init, 1);
      @(negedge clock);
      hit_pend  = 1'b0;
      exp_steps = 0;
      check_eq("hit_patch_start", patch_start, 1);
      check_eq("hit_step_count", step_count, 0);
      check_eq("hit_rho_out", rho_out, base);
    end else if (run) begin
      check_eq("next_patch_start", patch_start, 1);
    end else begin
      check_eq("idle_busy", busy, 0);
      check_eq("idle_load_init", load_init, 0);
      ended_idle = 1'b1;
    end
  endtask

  task automatic set_dly(input int a, input int b, input int c, input int d);
    dly[0] = a; dly[1] = b; dly[2] = c; dly[3] = d;
  endtask

  initial begin
    bit ended;
    int dmax;
    int hat;
    int drop;
    logic signed [17:0] s;
    logic signed [17:0] b;
    n_cmp = 0;
    n_err = 0;
    exp_steps = 0;
    hit_pend = 1'b0;
    reset = 1'b0;
    run = 1'b0;
    hit = 1'b0;
    patch_done = '0;
    sample_in = '0;
    rho_base = 18'sh08000;
    sample_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clock);
    check_eq("idle_busy_after_reset", busy, 0);

    // nominal step: all patches done 18 cycles after start
    start_run();
    set_dly(18, 18, 18, 18);
    do_step(18'sh10000, 18'sh08000, 0, -1, -1, 1'b0, ended);
    // patch 2 late, rho saturates
    set_dly(10, 10, 15, 10);
    do_step(18'sh1FFFF, 18'sh0FF00, 2, -1, -1, 1'b0, ended);
    // done coinciding with START is counted
    set_dly(0, 7, 7, 7);
    do_step(18'($urandom), 18'sh04000, 0, -1, -1, 1'b0, ended);
    set_dly(0, 0, 0, 0);
    do_step(-18'sh10000, 18'sh01000, 1, -1, -1, 1'b0, ended);
    // hit during WAIT with a long ready stall
    set_dly(12, 12, 12, 12);
    do_step(18'sh0ABCD, 18'sh06000, 10, 3, -1, 1'b0, ended);

    for (int k = 0; k < 40; k++) begin
      dmax = 0;
      for (int i = 0; i < NP; i++) begin
        dly[i] = $urandom_range(0, 30);
        if (dly[i] > dmax) dmax = dly[i];
      end
      hat  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, (dmax < 1) ? 1 : dmax) : -1;
      drop = ($urandom_range(0, 5) == 0) ? 1 : -1;
      s = 18'($urandom);
      if (k % 7 == 0) s = 18'sh20000;
      b = 18'($urandom);
      do_step(s, b, $urandom_range(0, 6), hat, drop, 1'b0, ended);
      if (ended) start_run();
    end

    // patch 3 never completes: timeout
    set_dly(5, 5, 5, -1);
    do_step(18'sh00100, 18'sh02000, 0, -1, 1, 1'b0, ended);
    @(negedge clock);
    check_eq("tmo_sticky_idle", timeout_err, 1);
    start_run();
    check_eq("tmo_sticky_run", timeout_err, 1);
    // reset during EMIT clears everything at once
    set_dly(3, 4, 5, 6);
    do_step(18'sh01234, 18'sh03000, 4, -1, -1, 1'b1, ended);
    check_eq("after_abort_busy", busy, 0);
    check_eq("after_abort_tmo", timeout_err, 0);
    start_run();
    set_dly(2, 9, 4, 1);
    do_step(18'sh18000, 18'sh00800, 3, -1, 1, 1'b0, ended);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
